// File: rtl/multi_block_display.sv
// Moving-block video overlay: N_BLK coloured rectangles bounce around the active
// area, updated once per frame, drawn over bg_color through a 2-stage pipeline.
module multi_block_display #(
  parameter int COLOR_DEPTH = 8,
  parameter int X_BITS      = 12,
  parameter int Y_BITS      = 12,
  parameter int H_ACT       = 1920,
  parameter int V_ACT       = 1080,
  parameter int N_BLK       = 4,
  parameter int BLK_W       = 64,
  parameter int BLK_H       = 64,
  parameter int STEP        = 4
) (
  input  logic                     pix_clk,
  input  logic                     rst,
  input  logic                     vs_in,
  input  logic                     hs_in,
  input  logic                     de_in,
  input  logic [X_BITS-1:0]        act_x,
  input  logic [Y_BITS-1:0]        act_y,
  input  logic                     move_en,
  input  logic [3*COLOR_DEPTH-1:0] bg_color,
  output logic                     vs_out,
  output logic                     hs_out,
  output logic                     de_out,
  output logic [3*COLOR_DEPTH-1:0] pixel_data,
  output logic [7:0]               frame_cnt
);

  localparam int CW = 3 * COLOR_DEPTH;

  // One extra bit on every bound comparison so edge-of-screen sums never wrap.
  localparam logic [X_BITS:0]   H_ACT_E = (X_BITS + 1)'(H_ACT);
  localparam logic [X_BITS:0]   BLK_W_E = (X_BITS + 1)'(BLK_W);
  localparam logic [X_BITS:0]   STEP_XE = (X_BITS + 1)'(STEP);
  localparam logic [Y_BITS:0]   V_ACT_E = (Y_BITS + 1)'(V_ACT);
  localparam logic [Y_BITS:0]   BLK_H_E = (Y_BITS + 1)'(BLK_H);
  localparam logic [Y_BITS:0]   STEP_YE = (Y_BITS + 1)'(STEP);
  localparam logic [X_BITS-1:0] X_MAX   = X_BITS'(H_ACT - BLK_W);
  localparam logic [X_BITS-1:0] X_STEP  = X_BITS'(STEP);
  localparam logic [Y_BITS-1:0] Y_MAX   = Y_BITS'(V_ACT - BLK_H);
  localparam logic [Y_BITS-1:0] Y_STEP  = Y_BITS'(STEP);

  localparam logic [COLOR_DEPTH-1:0] FULL = {COLOR_DEPTH{1'b1}};
  localparam logic [COLOR_DEPTH-1:0] ZERO = {COLOR_DEPTH{1'b0}};

  function automatic logic [CW-1:0] blk_color(input int idx);
    case (idx)
      0:       blk_color = {FULL, ZERO, ZERO};
      1:       blk_color = {ZERO, FULL, ZERO};
      2:       blk_color = {ZERO, ZERO, FULL};
      default: blk_color = {FULL, FULL, FULL};
    endcase
  endfunction

  // Frame start detection and frame counter
  logic       vs_q;
  logic       fs_q, fs_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       upd;

  always_comb begin
    fs_d        = vs_in & ~vs_q;
    frame_cnt_d = fs_q ? frame_cnt_q + 8'd1 : frame_cnt_q;
    upd         = fs_q & move_en;
  end

  // vs_q resets high so a vs_in already high at reset release is not an edge.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      vs_q        <= 1'b1;
      fs_q        <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      vs_q        <= vs_in;
      fs_q        <= fs_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Per-block position state and hit test
  logic [N_BLK-1:0] hit;

  for (genvar gi = 0; gi < N_BLK; gi++) begin : g_blk
    localparam logic [X_BITS-1:0] X_RST   = X_BITS'(gi * 256);
    localparam logic [Y_BITS-1:0] Y_RST   = Y_BITS'(gi * 128);
    localparam logic              DIR_RST = ((gi % 2) == 0);

    logic [X_BITS-1:0] x_q, x_d;
    logic [Y_BITS-1:0] y_q, y_d;
    logic              dx_q, dx_d;
    logic              dy_q, dy_d;
    logic [X_BITS:0]   x_e, ax_e;
    logic [Y_BITS:0]   y_e, ay_e;

    assign x_e  = {1'b0, x_q};
    assign y_e  = {1'b0, y_q};
    assign ax_e = {1'b0, act_x};
    assign ay_e = {1'b0, act_y};

    always_comb begin
      x_d  = x_q;
      dx_d = dx_q;
      if (upd) begin
        if (dx_q && (x_e + BLK_W_E + STEP_XE > H_ACT_E)) begin
          x_d  = X_MAX;
          dx_d = 1'b0;
        end else if (!dx_q && (x_q < X_STEP)) begin
          x_d  = '0;
          dx_d = 1'b1;
        end else if (dx_q) begin
          x_d = x_q + X_STEP;
        end else begin
          x_d = x_q - X_STEP;
        end
      end
    end

    always_comb begin
      y_d  = y_q;
      dy_d = dy_q;
      if (upd) begin
        if (dy_q && (y_e + BLK_H_E + STEP_YE > V_ACT_E)) begin
          y_d  = Y_MAX;
          dy_d = 1'b0;
        end else if (!dy_q && (y_q < Y_STEP)) begin
          y_d  = '0;
          dy_d = 1'b1;
        end else if (dy_q) begin
          y_d = y_q + Y_STEP;
        end else begin
          y_d = y_q - Y_STEP;
        end
      end
    end

    always_ff @(posedge pix_clk or posedge rst) begin
      if (rst) begin
        x_q  <= X_RST;
        y_q  <= Y_RST;
        dx_q <= DIR_RST;
        dy_q <= DIR_RST;
      end else begin
        x_q  <= x_d;
        y_q  <= y_d;
        dx_q <= dx_d;
        dy_q <= dy_d;
      end
    end

    assign hit[gi] = (ax_e >= x_e) && (ax_e < x_e + BLK_W_E) &&
                     (ay_e >= y_e) && (ay_e < y_e + BLK_H_E);
  end

  // Stage 1: hit vector plus timing and background
  logic [N_BLK-1:0] hit_q;
  logic             de1_q, vs1_q, hs1_q;
  logic [CW-1:0]    bg1_q;

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      hit_q <= '0;
      de1_q <= 1'b0;
      vs1_q <= 1'b0;
      hs1_q <= 1'b0;
      bg1_q <= '0;
    end else begin
      hit_q <= hit;
      de1_q <= de_in;
      vs1_q <= vs_in;
      hs1_q <= hs_in;
      bg1_q <= bg_color;
    end
  end

  // Stage 2: colour select, lowest index wins, blank outside active video
  logic [CW-1:0] pix_q, pix_d;
  logic          de2_q, vs2_q, hs2_q;

  always_comb begin
    pix_d = '0;
    if (de1_q) begin
      pix_d = bg1_q;
      for (int i = N_BLK - 1; i >= 0; i--) begin
        if (hit_q[i]) pix_d = blk_color(i);
      end
    end
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      pix_q <= '0;
      de2_q <= 1'b0;
      vs2_q <= 1'b0;
      hs2_q <= 1'b0;
    end else begin
      pix_q <= pix_d;
      de2_q <= de1_q;
      vs2_q <= vs1_q;
      hs2_q <= hs1_q;
    end
  end

  assign pixel_data = pix_q;
  assign de_out     = de2_q;
  assign vs_out     = vs2_q;
  assign hs_out     = hs2_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_multi_block_display.sv
// Self-checking bench for multi_block_display: three instances (default, single
// block, oversized blocks) checked against a rectangle-list reference model.
module tb_multi_block_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0, move_en = 1'b0;
  logic [11:0] act_x = '0, act_y = '0;
  logic [23:0] bg_color = '0;

  logic        m_vs, m_hs, m_de, n_vs, n_hs, n_de, b_vs, b_hs, b_de;
  logic [23:0] m_pix, n_pix, b_pix;
  logic [7:0]  m_fc, n_fc, b_fc;

  always #5 clk = ~clk;

  multi_block_display dut (
    .pix_clk(clk), .rst(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .act_x(act_x), .act_y(act_y), .move_en(move_en), .bg_color(bg_color),
    .vs_out(m_vs), .hs_out(m_hs), .de_out(m_de), .pixel_data(m_pix), .frame_cnt(m_fc));

  multi_block_display #(.N_BLK(1)) dut_n1 (
    .pix_clk(clk), .rst(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .act_x(act_x), .act_y(act_y), .move_en(move_en), .bg_color(bg_color),
    .vs_out(n_vs), .hs_out(n_hs), .de_out(n_de), .pixel_data(n_pix), .frame_cnt(n_fc));

  multi_block_display #(.BLK_W(512), .BLK_H(512)) dut_big (
    .pix_clk(clk), .rst(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .act_x(act_x), .act_y(act_y), .move_en(move_en), .bg_color(bg_color),
    .vs_out(b_vs), .hs_out(b_hs), .de_out(b_de), .pixel_data(b_pix), .frame_cnt(b_fc));

  // Reference model: block rectangles for the default-size instance
  int mx[4], my[4];
  bit mdx[4], mdy[4];
  int mfc;
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void bounce(inout int p, inout bit d, input int size, input int lim);
    if (d && (p + size + 4 > lim)) begin
      p = lim - size; d = 1'b0;
    end else if (!d && (p < 4)) begin
      p = 0; d = 1'b1;
    end else begin
      p = d ? p + 4 : p - 4;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      mx[i] = i * 256; my[i] = i * 128;
      mdx[i] = (i % 2 == 0); mdy[i] = (i % 2 == 0);
    end
    mfc = 0;
  endfunction

  function automatic void model_frame(input bit mv);
    mfc = (mfc + 1) % 256;
    if (mv) begin
      for (int i = 0; i < 4; i++) begin
        bounce(mx[i], mdx[i], 64, 1920);
        bounce(my[i], mdy[i], 64, 1080);
      end
    end
  endfunction

  function automatic logic [23:0] ref_pix(input int px, input int py, input int nblk,
                                          input int w, input int h, input logic [23:0] bg);
    logic [23:0] cols [4];
    cols[0] = 24'hFF0000; cols[1] = 24'h00FF00; cols[2] = 24'h0000FF; cols[3] = 24'hFFFFFF;
    for (int i = 0; i < nblk; i++) begin
      if (px >= mx[i] && px < mx[i] + w && py >= my[i] && py < my[i] + h) return cols[i];
    end
    return bg;
  endfunction

  task automatic do_frame();
    @(negedge clk); de_in = 1'b0; vs_in = 1'b1;
    @(negedge clk); @(negedge clk); vs_in = 1'b0;
    @(negedge clk); @(negedge clk);
    model_frame(move_en);
  endtask

  task automatic probe(input int px, input int py, input logic [23:0] bg,
                       output logic [23:0] pm, output logic [23:0] pn, output logic [23:0] pb);
    @(negedge clk);
    act_x = px[11:0]; act_y = py[11:0]; bg_color = bg;
    de_in = 1'b1; vs_in = 1'b0; hs_in = 1'b0;
    @(negedge clk); @(negedge clk);
    pm = m_pix; pn = n_pix; pb = b_pix;
    de_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vs_in = 1'b1; hs_in = 1'b1; de_in = 1'b1; bg_color = 24'hABCDEF;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({m_vs, m_hs, m_de} !== 3'b000) begin
      n_fail++; $display("FAIL reset_sync: got %b expected 000", {m_vs, m_hs, m_de});
    end
    n_checks++;
    if (m_pix !== 24'h0) begin n_fail++; $display("FAIL reset_pix: got %h expected 000000", m_pix); end
    n_checks++;
    if (m_fc !== 8'd0) begin n_fail++; $display("FAIL reset_fc: got %0d expected 0", m_fc); end
    n_checks++;
    if (b_pix !== 24'h0 || n_pix !== 24'h0) begin
      n_fail++; $display("FAIL reset_pix_var: got %h/%h expected 0", b_pix, n_pix);
    end
    vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0;
    @(negedge clk); rst = 1'b0;
    model_reset();
    $display("test_reset done");
  endtask

  task automatic test_first_pixel();
    logic [23:0] pm, pn, pb;
    probe(0, 0, 24'h101010, pm, pn, pb);
    n_checks++;
    if (pm !== 24'hFF0000) begin n_fail++; $display("FAIL first_pix: got %h expected FF0000", pm); end
    n_checks++;
    if (pn !== 24'hFF0000) begin n_fail++; $display("FAIL first_pix_n1: got %h expected FF0000", pn); end
    n_checks++;
    if (pb !== 24'hFF0000) begin n_fail++; $display("FAIL first_pix_big: got %h expected FF0000", pb); end
    $display("test_first_pixel (0,0) -> %h", pm);
  endtask

  task automatic test_sync_align();
    bit v[40], h[40], d[40];
    logic [23:0] bgh[40];
    logic [23:0] exp_pix;
    int edges = 0;
    bit prev = 1'b0;
    move_en = 1'b0;
    act_x = 12'd1500; act_y = 12'd1000;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        n_checks++;
        if ({m_vs, m_hs, m_de} !== {v[k-2], h[k-2], d[k-2]}) begin
          n_fail++;
          $display("FAIL sync_align[%0d]: got %b expected %b", k, {m_vs, m_hs, m_de}, {v[k-2], h[k-2], d[k-2]});
        end
        exp_pix = d[k-2] ? ref_pix(1500, 1000, 4, 64, 64, bgh[k-2]) : 24'h0;
        n_checks++;
        if (m_pix !== exp_pix) begin
          n_fail++; $display("FAIL stream_pix[%0d]: got %h expected %h", k, m_pix, exp_pix);
        end
      end
      v[k] = 1'($urandom_range(0, 1)); h[k] = 1'($urandom_range(0, 1));
      d[k] = 1'($urandom_range(0, 1)); bgh[k] = 24'($urandom);
      vs_in = v[k]; hs_in = h[k]; de_in = d[k]; bg_color = bgh[k];
      if (v[k] && !prev) edges++;
      prev = v[k];
    end
    @(negedge clk); vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0;
    repeat (3) @(negedge clk);
    for (int e = 0; e < edges; e++) model_frame(1'b0);
    n_checks++;
    if (m_fc !== 8'(mfc)) begin n_fail++; $display("FAIL stream_fc: got %0d expected %0d", m_fc, mfc); end
    $display("test_sync_align: %0d vs edges, frame_cnt %0d", edges, m_fc);
  endtask

  task automatic test_priority();
    logic [23:0] pm, pn, pb;
    int px[5] = '{300, 600, 800, 1100, 1500};
    int py[5] = '{150, 200, 300, 500, 1000};
    logic [23:0] eb[5] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF, 24'h123456};
    for (int k = 0; k < 5; k++) begin
      probe(px[k], py[k], 24'h123456, pm, pn, pb);
      n_checks++;
      if (pb !== eb[k]) begin
        n_fail++; $display("FAIL prio_big(%0d,%0d): got %h expected %h", px[k], py[k], pb, eb[k]);
      end
      n_checks++;
      if (pm !== ref_pix(px[k], py[k], 4, 64, 64, 24'h123456)) begin
        n_fail++; $display("FAIL prio_main(%0d,%0d): got %h expected %h", px[k], py[k], pm,
                           ref_pix(px[k], py[k], 4, 64, 64, 24'h123456));
      end
      $display("priority (%0d,%0d) big=%h main=%h", px[k], py[k], pb, pm);
    end
    probe(256, 128, 24'h123456, pm, pn, pb);
    n_checks++;
    if (pn !== 24'h123456) begin n_fail++; $display("FAIL n1_absent: got %h expected 123456", pn); end
    n_checks++;
    if (pm !== 24'h00FF00) begin n_fail++; $display("FAIL blk1_green: got %h expected 00FF00", pm); end
  endtask

  task automatic test_positions();
    logic [23:0] pm, pn, pb, bg;
    int px, py;
    int ox[4] = '{0, 63, -1, 64};
    int oy[4] = '{0, 63, 0, 63};
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 4; c++) begin
        px = mx[i] + ox[c]; py = my[i] + oy[c];
        if (px >= 0) begin
          bg = 24'($urandom);
          probe(px, py, bg, pm, pn, pb);
          n_checks++;
          if (pm !== ref_pix(px, py, 4, 64, 64, bg)) begin
            n_fail++; $display("FAIL pos_blk%0d(%0d,%0d): got %h expected %h", i, px, py, pm,
                               ref_pix(px, py, 4, 64, 64, bg));
          end
          if (i == 0) begin
            n_checks++;
            if (pn !== ref_pix(px, py, 1, 64, 64, bg)) begin
              n_fail++; $display("FAIL pos_n1(%0d,%0d): got %h expected %h", px, py, pn,
                                 ref_pix(px, py, 1, 64, 64, bg));
            end
          end
        end
      end
    end
    $display("positions frame=%0d b0=(%0d,%0d) b1=(%0d,%0d)", mfc, mx[0], my[0], mx[1], my[1]);
  endtask

  task automatic test_random_pixels(input int n);
    logic [23:0] pm, pn, pb, bg;
    int i, px, py;
    for (int k = 0; k < n; k++) begin
      i  = int'($urandom_range(0, 3));
      px = mx[i] + int'($urandom_range(0, 79)) - 8;
      py = my[i] + int'($urandom_range(0, 79)) - 8;
      if (px < 0) px = 0;
      if (py < 0) py = 0;
      bg = 24'($urandom);
      probe(px, py, bg, pm, pn, pb);
      n_checks++;
      if (pm !== ref_pix(px, py, 4, 64, 64, bg) || pn !== ref_pix(px, py, 1, 64, 64, bg)) begin
        n_fail++; $display("FAIL rand_pix(%0d,%0d): got %h/%h expected %h/%h", px, py, pm, pn,
                           ref_pix(px, py, 4, 64, 64, bg), ref_pix(px, py, 1, 64, 64, bg));
      end
    end
    $display("random pixels: %0d probes at frame %0d", n, mfc);
  endtask

  task automatic test_bounce_y();
    logic [23:0] pm, pn, pb;
    move_en = 1'b1;
    repeat (33) do_frame();
    probe(124, 0, 24'h0A0B0C, pm, pn, pb);
    n_checks++;
    if (pm !== 24'h00FF00) begin n_fail++; $display("FAIL b1_top_corner: got %h expected 00FF00", pm); end
    probe(123, 0, 24'h0A0B0C, pm, pn, pb);
    n_checks++;
    if (pm !== 24'h0A0B0C) begin n_fail++; $display("FAIL b1_left_out: got %h expected 0A0B0C", pm); end
    probe(187, 63, 24'h0A0B0C, pm, pn, pb);
    n_checks++;
    if (pm !== 24'h00FF00) begin n_fail++; $display("FAIL b1_far_corner: got %h expected 00FF00", pm); end
    probe(188, 63, 24'h0A0B0C, pm, pn, pb);
    n_checks++;
    if (pm !== 24'h0A0B0C) begin n_fail++; $display("FAIL b1_right_out: got %h expected 0A0B0C", pm); end
    test_positions();
    do_frame();
    probe(120, 4, 24'h0A0B0C, pm, pn, pb);
    n_checks++;
    if (pm !== 24'h00FF00) begin n_fail++; $display("FAIL b1_reversed: got %h expected 00FF00", pm); end
    probe(120, 3, 24'h0A0B0C, pm, pn, pb);
    n_checks++;
    if (pm !== 24'h0A0B0C) begin n_fail++; $display("FAIL b1_above: got %h expected 0A0B0C", pm); end
  endtask

  task automatic test_edge_clamp();
    logic [23:0] pm, pn, pb;
    int xs[4] = '{1852, 1856, 1856, 1852};
    for (int f = 34; f < 463; f++) begin
      do_frame();
      if (f % 100 == 0) test_random_pixels(4);
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) do_frame();
      probe(xs[k], my[0], 24'h202020, pm, pn, pb);
      n_checks++;
      if (pm !== 24'hFF0000 || pn !== 24'hFF0000) begin
        n_fail++; $display("FAIL clamp_in[%0d] x=%0d: got %h/%h expected FF0000", k, xs[k], pm, pn);
      end
      probe(xs[k] - 1, my[0], 24'h202020, pm, pn, pb);
      n_checks++;
      if (pn !== 24'h202020) begin
        n_fail++; $display("FAIL clamp_left[%0d] x=%0d: got %h expected 202020", k, xs[k] - 1, pn);
      end
      $display("edge clamp step %0d: block0 x=%0d", k, xs[k]);
    end
    test_positions();
  endtask

  task automatic test_hold();
    int fc0;
    move_en = 1'b0;
    fc0 = mfc;
    repeat (10) do_frame();
    n_checks++;
    if (m_fc !== 8'((fc0 + 10) % 256)) begin
      n_fail++; $display("FAIL hold_fc10: got %0d expected %0d", m_fc, (fc0 + 10) % 256);
    end
    test_positions();
    fc0 = mfc;
    repeat (256) do_frame();
    n_checks++;
    if (m_fc !== 8'(fc0)) begin n_fail++; $display("FAIL fc_wrap: got %0d expected %0d", m_fc, fc0); end
    test_positions();
  endtask

  task automatic test_reset_midline();
    move_en = 1'b1;
    @(negedge clk);
    act_x = 12'(mx[0]); act_y = 12'(my[0]); bg_color = 24'h555555; de_in = 1'b1; hs_in = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (m_pix !== 24'hFF0000) begin n_fail++; $display("FAIL pre_reset_pix: got %h expected FF0000", m_pix); end
    @(posedge clk); #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({m_vs, m_hs, m_de} !== 3'b000 || m_pix !== 24'h0 || m_fc !== 8'd0) begin
      n_fail++; $display("FAIL async_reset: got %b %h %0d expected 000 000000 0", {m_vs, m_hs, m_de}, m_pix, m_fc);
    end
    @(negedge clk); vs_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    vs_in = 1'b0; de_in = 1'b0; hs_in = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (m_fc !== 8'(mfc)) begin n_fail++; $display("FAIL release_vs_high: got %0d expected %0d", m_fc, mfc); end
    test_positions();
    do_frame();
    n_checks++;
    if (m_fc !== 8'(mfc)) begin n_fail++; $display("FAIL first_frame_fc: got %0d expected %0d", m_fc, mfc); end
    test_positions();
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_sync_align();
    test_priority();
    test_positions();
    test_random_pixels(20);
    test_bounce_y();
    test_edge_clamp();
    test_random_pixels(20);
    test_hold();
    test_reset_midline();
    test_random_pixels(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
